// File: rtl/computational_unit_pkg.sv
// Shared constants for the computational unit: data_bus source codes, ALU
// function codes and reg_en bit positions.
package computational_unit_pkg;

  localparam logic [3:0] SRC_X0    = 4'd0;
  localparam logic [3:0] SRC_X1    = 4'd1;
  localparam logic [3:0] SRC_Y0    = 4'd2;
  localparam logic [3:0] SRC_Y1    = 4'd3;
  localparam logic [3:0] SRC_R     = 4'd4;
  localparam logic [3:0] SRC_M     = 4'd5;
  localparam logic [3:0] SRC_I     = 4'd6;
  localparam logic [3:0] SRC_DM    = 4'd7;
  localparam logic [3:0] SRC_IR    = 4'd8;
  localparam logic [3:0] SRC_IPINS = 4'd9;

  localparam logic [2:0] FN_NEG   = 3'b000;
  localparam logic [2:0] FN_SUB   = 3'b001;
  localparam logic [2:0] FN_ADD   = 3'b010;
  localparam logic [2:0] FN_MULHI = 3'b011;
  localparam logic [2:0] FN_MULLO = 3'b100;
  localparam logic [2:0] FN_XOR   = 3'b101;
  localparam logic [2:0] FN_AND   = 3'b110;
  localparam logic [2:0] FN_NOT   = 3'b111;

  localparam int EN_X0    = 0;
  localparam int EN_X1    = 1;
  localparam int EN_Y0    = 2;
  localparam int EN_Y1    = 3;
  localparam int EN_R     = 4;
  localparam int EN_M     = 5;
  localparam int EN_I     = 6;
  localparam int EN_DM_WE = 7;
  localparam int EN_O     = 8;

endpackage

// File: rtl/computational_unit_alu.sv
// Combinational 4-bit ALU (module cu_alu). The multiplier exists only when
// CU_MULTIPLY_EN is defined; otherwise the multiply codes pass r through.
module cu_alu
  import computational_unit_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [3:0] r,
  input  logic [3:0] fn,
  output logic [3:0] alu_out
);

`ifdef CU_MULTIPLY_EN
  logic [7:0] prod;
  assign prod = {4'b0000, x} * {4'b0000, y};
`endif

  always_comb begin
    alu_out = r;
    case (fn[2:0])
      // fn[3] turns the two unary codes into no-ops that keep r
      FN_NEG:   alu_out = fn[3] ? r : (4'd0 - x);
      FN_SUB:   alu_out = x - y;
      FN_ADD:   alu_out = x + y;
`ifdef CU_MULTIPLY_EN
      FN_MULHI: alu_out = prod[7:4];
      FN_MULLO: alu_out = prod[3:0];
`else
      FN_MULHI: alu_out = r;
      FN_MULLO: alu_out = r;
`endif
      FN_XOR:   alu_out = x ^ y;
      FN_AND:   alu_out = x & y;
      FN_NOT:   alu_out = fn[3] ? r : ~x;
      default:  alu_out = r;
    endcase
  end

endmodule

// File: rtl/computational_unit.sv
// Register file, data_bus source mux and result register of the 4-bit
// computational unit. Optional multiply functions: define CU_MULTIPLY_EN.
module computational_unit
  import computational_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync_reset,
  input  logic [8:0] reg_en,
  input  logic [3:0] source_sel,
  input  logic [3:0] nibble_ir,
  input  logic       i_sel,
  input  logic       x_sel,
  input  logic       y_sel,
  input  logic [3:0] dm,
  input  logic [3:0] i_pins,
  output logic [3:0] x0,
  output logic [3:0] x1,
  output logic [3:0] y0,
  output logic [3:0] y1,
  output logic [3:0] r,
  output logic [3:0] m,
  output logic [3:0] i,
  output logic [3:0] o_reg,
  output logic [3:0] data_bus,
  output logic [3:0] alu_out,
  output logic       r_eq_0
);

  logic [3:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [3:0] r_q, r_d, m_q, m_d, i_q, i_d, o_q, o_d;
  logic       r_eq_0_q, r_eq_0_d;
  logic       unused_dm_we;

  // Data-memory write enable is carried in reg_en but consumed elsewhere
  assign unused_dm_we = reg_en[EN_DM_WE];

  always_comb begin
    data_bus = 4'h0;
    case (source_sel)
      SRC_X0:    data_bus = x0_q;
      SRC_X1:    data_bus = x1_q;
      SRC_Y0:    data_bus = y0_q;
      SRC_Y1:    data_bus = y1_q;
      SRC_R:     data_bus = r_q;
      SRC_M:     data_bus = m_q;
      SRC_I:     data_bus = i_q;
      SRC_DM:    data_bus = dm;
      SRC_IR:    data_bus = nibble_ir;
      SRC_IPINS: data_bus = i_pins;
      default:   data_bus = 4'h0;
    endcase
  end

  cu_alu u_alu (
    .x       (x_sel ? x1_q : x0_q),
    .y       (y_sel ? y1_q : y0_q),
    .r       (r_q),
    .fn      (nibble_ir),
    .alu_out (alu_out)
  );

  always_comb begin
    x0_d     = reg_en[EN_X0] ? data_bus : x0_q;
    x1_d     = reg_en[EN_X1] ? data_bus : x1_q;
    y0_d     = reg_en[EN_Y0] ? data_bus : y0_q;
    y1_d     = reg_en[EN_Y1] ? data_bus : y1_q;
    m_d      = reg_en[EN_M]  ? data_bus : m_q;
    o_d      = reg_en[EN_O]  ? data_bus : o_q;
    i_d      = i_q;
    r_d      = r_q;
    r_eq_0_d = r_eq_0_q;
    if (reg_en[EN_I]) i_d = i_sel ? (i_q + m_q) : data_bus;
    // sync_reset clears only the result path; other loads still proceed
    if (sync_reset) begin
      r_d      = 4'h0;
      r_eq_0_d = 1'b1;
    end else if (reg_en[EN_R]) begin
      r_d      = alu_out;
      r_eq_0_d = (alu_out == 4'h0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q     <= 4'h0;
      x1_q     <= 4'h0;
      y0_q     <= 4'h0;
      y1_q     <= 4'h0;
      r_q      <= 4'h0;
      m_q      <= 4'h0;
      i_q      <= 4'h0;
      o_q      <= 4'h0;
      r_eq_0_q <= 1'b1;
    end else begin
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      r_q      <= r_d;
      m_q      <= m_d;
      i_q      <= i_d;
      o_q      <= o_d;
      r_eq_0_q <= r_eq_0_d;
    end
  end

  assign x0     = x0_q;
  assign x1     = x1_q;
  assign y0     = y0_q;
  assign y1     = y1_q;
  assign r      = r_q;
  assign m      = m_q;
  assign i      = i_q;
  assign o_reg  = o_q;
  assign r_eq_0 = r_eq_0_q;

endmodule

// File: tb/tb_computational_unit.sv
// Vector-table bench for computational_unit; expected values are pushed to a
// queue when a record is driven and popped after the clock edge.
module tb_computational_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sync_reset = 1'b0;
  logic [8:0] reg_en = '0;
  logic [3:0] source_sel = '0, nibble_ir = '0, dm = 4'd7, i_pins = '0;
  logic       i_sel = 1'b0, x_sel = 1'b0, y_sel = 1'b0;
  logic [3:0] x0, x1, y0, y1, r, m, i, o_reg, data_bus, alu_out;
  logic       r_eq_0;

  int n_cmp = 0;
  int n_bad = 0;

  // Check ids: 0..7 = x0,x1,y0,y1,r,m,i,o_reg ; 8 = r_eq_0 ; 15 = nothing
  localparam logic [3:0] C_X0 = 0, C_X1 = 1, C_Y0 = 2, C_Y1 = 3, C_R = 4,
                         C_M = 5, C_I = 6, C_O = 7, C_Z = 8, C_NONE = 15;
  localparam logic [8:0] E_X0 = 9'h001, E_X1 = 9'h002, E_Y0 = 9'h004,
                         E_Y1 = 9'h008, E_R = 9'h010, E_M = 9'h020,
                         E_I = 9'h040, E_O = 9'h100;

`ifdef CU_MULTIPLY_EN
  localparam logic [3:0] EXP_MH = 4'd6, EXP_ML = 4'd4;
`else
  localparam logic [3:0] EXP_MH = 4'd11, EXP_ML = 4'd11;
`endif

  typedef struct {
    logic [8:0] en;
    logic [3:0] src;
    logic [3:0] nib;
    logic [3:0] pins;
    logic       isel, xsel, ysel, srst;
    logic [3:0] chk;
    logic [3:0] exp_v;
    logic       chkz;
    logic       expz;
  } vec_t;

  vec_t tbl[$];
  logic [3:0] exp_q[$];
  logic [3:0] id_q[$];

  computational_unit dut (
    .clk(clk), .rst_n(rst_n), .sync_reset(sync_reset), .reg_en(reg_en),
    .source_sel(source_sel), .nibble_ir(nibble_ir), .i_sel(i_sel),
    .x_sel(x_sel), .y_sel(y_sel), .dm(dm), .i_pins(i_pins),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .r(r), .m(m), .i(i),
    .o_reg(o_reg), .data_bus(data_bus), .alu_out(alu_out), .r_eq_0(r_eq_0)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] dut_val(input logic [3:0] id);
    case (id)
      C_X0: dut_val = x0;
      C_X1: dut_val = x1;
      C_Y0: dut_val = y0;
      C_Y1: dut_val = y1;
      C_R:  dut_val = r;
      C_M:  dut_val = m;
      C_I:  dut_val = i;
      C_O:  dut_val = o_reg;
      C_Z:  dut_val = {3'b000, r_eq_0};
      default: dut_val = 4'h0;
    endcase
  endfunction

  function automatic vec_t mk(input logic [8:0] en, input logic [3:0] src,
                              input logic [3:0] nib, input logic [3:0] pins,
                              input logic isel, input logic xsel,
                              input logic ysel, input logic srst,
                              input logic [3:0] chk, input logic [3:0] exp_v,
                              input logic chkz, input logic expz);
    vec_t v;
    v.en = en; v.src = src; v.nib = nib; v.pins = pins;
    v.isel = isel; v.xsel = xsel; v.ysel = ysel; v.srst = srst;
    v.chk = chk; v.exp_v = exp_v; v.chkz = chkz; v.expz = expz;
    return v;
  endfunction

  task automatic compare(input string nm, input logic [3:0] act,
                         input logic [3:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // driver: apply one record between edges, score the state after the edge
  task automatic apply(input vec_t v, input int idx);
    logic [3:0] id, ev;
    @(negedge clk);
    reg_en = v.en; source_sel = v.src; nibble_ir = v.nib; i_pins = v.pins;
    i_sel = v.isel; x_sel = v.xsel; y_sel = v.ysel; sync_reset = v.srst;
    if (v.chk != C_NONE) begin
      exp_q.push_back(v.exp_v);
      id_q.push_back(v.chk);
    end
    if (v.chkz) begin
      exp_q.push_back({3'b000, v.expz});
      id_q.push_back(C_Z);
    end
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      id = id_q.pop_front();
      compare($sformatf("vec%0d id%0d", idx, id), dut_val(id), ev);
    end
  endtask

  initial begin
    // source_sel sweep 0..9 into o_reg; state at that point:
    // x0=0 x1=15 y0=10 y1=10 r=1 m=2 i=8 dm=7 ir=1 pins=13
    logic [3:0] sweep_exp[10];
    sweep_exp = '{4'd0, 4'd15, 4'd10, 4'd10, 4'd1, 4'd2, 4'd8, 4'd7, 4'd1, 4'd13};

    // load path
    tbl.push_back(mk(E_X0, 9, 0, 5,  0,0,0,0, C_X0, 5,  0,0));
    tbl.push_back(mk(E_X1, 9, 0, 1,  0,0,0,0, C_X1, 1,  0,0));
    tbl.push_back(mk(E_Y0, 9, 0, 10, 0,0,0,0, C_Y0, 10, 0,0));
    tbl.push_back(mk(E_Y1, 9, 0, 4,  0,0,0,0, C_Y1, 4,  0,0));
    tbl.push_back(mk(0,    9, 0, 9,  0,0,0,0, C_X0, 5,  1,1));
    // add / subtract
    tbl.push_back(mk(E_R,  0, 4'b0010, 0, 0,0,0,0, C_R, 15, 1,0));
    tbl.push_back(mk(E_R,  0, 4'b0001, 0, 0,0,0,0, C_R, 11, 1,0));
    // x1 and y1 both load 10 from nibble_ir in the same edge
    tbl.push_back(mk(E_X1|E_Y1, 8, 4'b1010, 0, 0,0,0,0, C_X1, 10, 0,0));
    tbl.push_back(mk(0, 0, 0, 0, 0,0,0,0, C_Y1, 10, 1,0));
    // multiply and logic
    tbl.push_back(mk(E_R, 0, 4'b1011, 0, 0,1,1,0, C_R, EXP_MH, 1,0));
    tbl.push_back(mk(E_R, 0, 4'b1100, 0, 0,1,1,0, C_R, EXP_ML, 1,0));
    tbl.push_back(mk(E_R, 0, 4'b0101, 0, 0,1,0,0, C_R, 0, 1,1));
    tbl.push_back(mk(E_R, 0, 4'b0110, 0, 0,1,0,0, C_R, 10, 1,0));
    // negate / invert / no-ops
    tbl.push_back(mk(E_X0, 10, 0, 0, 0,0,0,0, C_X0, 0, 0,0));
    tbl.push_back(mk(E_R, 0, 4'b0111, 0, 0,0,0,0, C_R, 15, 1,0));
    tbl.push_back(mk(E_X1, 9, 0, 15, 0,0,0,0, C_X1, 15, 0,0));
    tbl.push_back(mk(E_R, 0, 4'b0000, 0, 0,1,0,0, C_R, 1, 1,0));
    tbl.push_back(mk(E_R, 0, 4'b1000, 0, 0,1,0,0, C_R, 1, 1,0));
    tbl.push_back(mk(E_R, 0, 4'b1111, 0, 0,1,0,0, C_R, 1, 1,0));
    // index register
    tbl.push_back(mk(E_M, 9, 0, 2, 0,0,0,0, C_M, 2, 0,0));
    tbl.push_back(mk(E_I, 9, 0, 6, 0,0,0,0, C_I, 6, 0,0));
    tbl.push_back(mk(E_I, 9, 0, 3, 1,0,0,0, C_I, 8, 0,0));
    tbl.push_back(mk(0,   9, 0, 3, 1,0,0,0, C_I, 8, 0,0));
    for (int s = 0; s < 10; s++)
      tbl.push_back(mk(E_O, s[3:0], 4'd1, 4'd13, 0,0,0,0, C_O, sweep_exp[s], 0,0));
    tbl.push_back(mk(E_O, 12, 4'd1, 4'd13, 0,0,0,0, C_O, 0, 0,0));
    // sync clear: r = ~9 = 6, then clear while x0 still loads
    tbl.push_back(mk(E_X0, 9, 0, 9, 0,0,0,0, C_X0, 9, 0,0));
    tbl.push_back(mk(E_R, 0, 4'b0111, 0, 0,0,0,0, C_R, 6, 1,0));
    tbl.push_back(mk(E_X0, 9, 0, 3, 0,0,0,1, C_R, 0, 1,1));
    tbl.push_back(mk(0, 0, 0, 0, 0,0,0,0, C_X0, 3, 0,0));
    tbl.push_back(mk(0, 0, 0, 0, 0,0,0,0, C_Y0, 10, 0,0));
    tbl.push_back(mk(0, 0, 0, 0, 0,0,0,0, C_M, 2, 1,1));
    // sync clear wins over a concurrent r load: 3 + 10 = 13 first
    tbl.push_back(mk(E_R, 0, 4'b0010, 0, 0,0,0,0, C_R, 13, 1,0));
    tbl.push_back(mk(E_R, 0, 4'b0010, 0, 0,0,0,1, C_R, 0, 1,1));
    // wrap-around: 3 - 10 = 9
    tbl.push_back(mk(E_R, 0, 4'b0001, 0, 0,0,0,0, C_R, 9, 1,0));

    // reset state while rst_n is held low
    #12;
    compare("rst x0", x0, 0);    compare("rst x1", x1, 0);
    compare("rst y0", y0, 0);    compare("rst y1", y1, 0);
    compare("rst r", r, 0);      compare("rst m", m, 0);
    compare("rst i", i, 0);      compare("rst o_reg", o_reg, 0);
    compare("rst r_eq_0", {3'b000, r_eq_0}, 4'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], k);

    // combinational data_bus and alu_out between edges (x0=3, y0=10)
    @(negedge clk);
    reg_en = '0; sync_reset = 1'b0; source_sel = 4'd2; nibble_ir = 4'b0010;
    x_sel = 1'b0; y_sel = 1'b0;
    #1;
    compare("comb data_bus", data_bus, 10);
    compare("comb alu_out", alu_out, 13);

    // asynchronous reset asserted mid-cycle, no clock edge needed
    #1;
    rst_n = 1'b0;
    #1;
    compare("async x0", x0, 0);
    compare("async y0", y0, 0);
    compare("async r", r, 0);
    compare("async i", i, 0);
    compare("async r_eq_0", {3'b000, r_eq_0}, 4'd1);
    // still held in reset across an enabled edge
    reg_en = E_X0; source_sel = 4'd9; i_pins = 4'd7;
    @(posedge clk);
    #1;
    compare("held x0", x0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare("post-reset x0", x0, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/computational_unit.md
COMPUTATIONAL_UNIT -- requirements
Module: computational_unit

Interface
REQ-001 The module SHALL have exactly one clock and an asynchronous, active-low reset; all registers update on the rising edge of the clock.
REQ-002 Port `clk`, input, 1 bit: rising-edge system clock.
REQ-003 Port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-004 Port `sync_reset`, input, 1 bit: synchronous active-high functional clear of `r`/`r_eq_0`.
REQ-005 Port `reg_en`, input, 9 bits: load enables. Bit 0 is `x0`, bit 1 is `x1`, bit 2 is `y0`, bit 3 is `y1`, bit 4 is `r`, bit 5 is `m`, bit 6 is `i`. Bit 7 is unused (it is the data-memory write enable, which lives outside this block). Bit 8 is `o_reg`.
REQ-006 Port `source_sel`, input, 4 bits: data_bus source select.
REQ-007 Port `nibble_ir`, input, 4 bits: instruction nibble; it is both the immediate operand and the ALU function.
REQ-008 Ports `i_sel`, `x_sel` and `y_sel`, inputs, 1 bit each:
- `i_sel`: source of the `i` register's next value.
- `x_sel`: ALU X operand, 0 = `x0`, 1 = `x1`.
- `y_sel`: ALU Y operand, 0 = `y0`, 1 = `y1`.
REQ-009 Ports `dm` and `i_pins`, inputs, 4 bits each: data-memory read data and external input pins.
REQ-010 Ports `x0`, `x1`, `y0`, `y1`, `r`, `m`, `i` and `o_reg`, outputs, 4 bits each: register contents.
REQ-011 Port `data_bus`, output, 4 bits: combinational source mux output.
REQ-012 Port `alu_out`, output, 4 bits: combinational ALU result.
REQ-013 Port `r_eq_0`, output, 1 bit: registered zero flag of `r`.

Function
REQ-014 `data_bus` SHALL be selected by `source_sel` as follows:
- 0 = `x0`, 1 = `x1`, 2 = `y0`, 3 = `y1`
- 4 = `r`, 5 = `m`, 6 = `i`
- 7 = `dm`, 8 = `nibble_ir`, 9 = `i_pins`
- 10 to 15 = 4'h0
REQ-015 `x0`, `x1`, `y0`, `y1`, `m` and `o_reg` SHALL each load `data_bus` on a clock edge when their `reg_en` bit is 1, and otherwise hold.
REQ-016 When `reg_en[6]` is 1, `i` SHALL load `data_bus` if `i_sel` = 0, or `i + m` (mod 16) if `i_sel` = 1; otherwise `i` holds.
REQ-017 ALU operands SHALL be X = (`x_sel` ? `x1` : `x0`) and Y = (`y_sel` ? `y1` : `y0`).
REQ-018 The ALU function SHALL be `nibble_ir[2:0]`, with all results mod 16:
- 000 with `nibble_ir[3]` = 0: −X (two's complement).
- 001: X − Y.
- 010: X + Y.
- 011: high nibble of the unsigned 8-bit product X*Y.
- 100: low nibble of X*Y.
- 101: X ^ Y.
- 110: X & Y.
- 111 with `nibble_ir[3]` = 0: ~X.
REQ-019 Function codes 000 and 111 with `nibble_ir[3]` = 1 SHALL be no-ops: `alu_out` = `r`.
REQ-020 When `reg_en[4]` is 1 and `sync_reset` is 0, `r` SHALL load `alu_out` and `r_eq_0` SHALL load (`alu_out` == 0), in the same edge.
REQ-021 When `reg_en[4]` is 0 and `sync_reset` is 0, `r` and `r_eq_0` SHALL hold.
REQ-022 When `sync_reset` is 1 at a clock edge, `r` SHALL become 0 and `r_eq_0` SHALL become 1, regardless of `reg_en[4]`. During that edge, all other registers SHALL still obey their enables.
REQ-023 Latency SHALL be one clock from enable to register update.
REQ-024 Simultaneous enables SHALL all be honoured in the same edge, each register loading the same pre-edge `data_bus`/`alu_out`.
REQ-025 There SHALL be no carry or overflow output; wrap-around is silent.

Reset
REQ-026 While `rst_n` is 0, all registers (`x0`, `x1`, `y0`, `y1`, `r`, `m`, `i`, `o_reg`) SHALL be 4'h0 and `r_eq_0` SHALL be 1, asynchronously.
REQ-027 Deassertion of `rst_n` SHALL take effect at the next rising clock edge; `rst_n` SHALL have priority over `sync_reset` and all enables.

Configuration
REQ-028 Macro `CU_MULTIPLY_EN`, when defined, SHALL include the multiplier and functions 011/100 per REQ-018.
REQ-029 When `CU_MULTIPLY_EN` is undefined, functions 011 and 100 SHALL behave as no-ops (`alu_out` = `r`) and no multiplier SHALL be synthesized.

Structure
REQ-030 A shared package SHALL hold:
- the `source_sel` code constants;
- the ALU function-code constants;
- the `reg_en` bit-index constants.
REQ-031 The ALU SHALL be a separate combinational sub-module named `cu_alu`; the registers and `data_bus` mux SHALL reside in `computational_unit`.

Verification
REQ-032 Load path: pulse `rst_n` low → all registers 0 and `r_eq_0` = 1. Then, with `source_sel` = 9, load `i_pins` values 5, 1, 10, 4 into `x0`, `x1`, `y0`, `y1` → those four registers read 5, 1, 10, 4.
REQ-033 Add and subtract: `x0` = 5, `y0` = 10, `reg_en[4]` = 1.
- `nibble_ir` = 0010 → `r` = 15, `r_eq_0` = 0.
- `nibble_ir` = 0001 → `r` = 11.
REQ-034 Multiply and logic: `x1` = `y1` = 10, `x_sel` = `y_sel` = 1.
- `nibble_ir` = 1011 → `r` = 6.
- `nibble_ir` = 1100 → `r` = 4.
- `nibble_ir` = 0101 with `y_sel` = 0 and `y0` = 10 → `r` = 0, `r_eq_0` = 1.
REQ-035 Negate and invert:
- `x0` = 0, `nibble_ir` = 0111 → `r` = 15.
- `x1` = 15, `x_sel` = 1, `nibble_ir` = 0000 → `r` = 1.
- `nibble_ir` = 1000 or 1111 → `r` unchanged.
REQ-036 Index and bus: `m` = 2, `i` = 6; `i_sel` = 1 with a one-cycle `reg_en[6]` → `i` = 8. Then, with `reg_en[8]` = 1, sweep `source_sel` 0 to 9 → `o_reg` equals each selected source; `source_sel` = 8 with `nibble_ir` = 1 → `o_reg` = 1.
REQ-037 Sync clear: `r` = 6, assert `sync_reset` for one edge with `reg_en[4]` = 0 → `r` = 0 and `r_eq_0` = 1; all other registers unchanged.
